// File: rtl/status_flag_unit_pkg.sv
// Shared ALU opcodes and flag bit positions for the status flag unit.
package status_flag_unit_pkg;

    typedef enum logic [3:0] {
        CmdNop = 4'h0,
        CmdMov = 4'h1,
        CmdAdd = 4'h2,
        CmdAdc = 4'h3,
        CmdSub = 4'h4,
        CmdSbc = 4'h5,
        CmdAnd = 4'h6,
        CmdOrr = 4'h7,
        CmdEor = 4'h8,
        CmdMvn = 4'h9,
        CmdCmp = 4'hA,
        CmdTst = 4'hB
    } exe_cmd_e;

    localparam int unsigned FlagN = 3;
    localparam int unsigned FlagZ = 2;
    localparam int unsigned FlagC = 1;
    localparam int unsigned FlagV = 0;

    typedef logic [3:0] flags_t;

endpackage

// File: rtl/status_flag_unit_flag_alu.sv
// Combinational ALU and next-flag generation; consumes current flags for ADC/SBC carry and V hold.
module flag_alu
    import status_flag_unit_pkg::*;
#(
    parameter int unsigned DataW = 32
) (
    input  logic [3:0]       cmd_i,
    input  logic [DataW-1:0] op_a_i,
    input  logic [DataW-1:0] op_b_i,
    input  logic             shift_carry_i,
    input  flags_t           flags_i,
    output logic [DataW-1:0] result_o,
    output flags_t           flags_o,
    output logic             decoded_o,
    output logic             test_op_o
);

    logic             is_arith;
    logic             is_sub;
    logic             carry_in;
    logic [DataW:0]   ext_sum;
    logic [DataW-1:0] res;

    always_comb begin
        is_arith  = 1'b0;
        is_sub    = 1'b0;
        carry_in  = 1'b0;
        decoded_o = 1'b1;
        test_op_o = 1'b0;
        res       = '0;
        ext_sum   = '0;
        flags_o   = flags_i;

        case (cmd_i)
            CmdMov: res = op_b_i;
            CmdMvn: res = ~op_b_i;
            CmdAnd: res = op_a_i & op_b_i;
            CmdOrr: res = op_a_i | op_b_i;
            CmdEor: res = op_a_i ^ op_b_i;
            CmdTst: begin
                res       = op_a_i & op_b_i;
                test_op_o = 1'b1;
            end
            CmdAdd: is_arith = 1'b1;
            CmdAdc: begin
                is_arith = 1'b1;
                carry_in = flags_i[FlagC];
            end
            CmdSub: begin
                is_arith = 1'b1;
                is_sub   = 1'b1;
                carry_in = 1'b1;
            end
            CmdCmp: begin
                is_arith  = 1'b1;
                is_sub    = 1'b1;
                carry_in  = 1'b1;
                test_op_o = 1'b1;
            end
            CmdSbc: begin
                is_arith = 1'b1;
                is_sub   = 1'b1;
                carry_in = flags_i[FlagC];
            end
            default: decoded_o = 1'b0;
        endcase

        // Subtract as a + ~b + cin so bit DataW is directly NOT borrow.
        if (is_arith) begin
            ext_sum = {1'b0, op_a_i} + {1'b0, (is_sub ? ~op_b_i : op_b_i)}
                    + {{DataW{1'b0}}, carry_in};
            res     = ext_sum[DataW-1:0];
        end

        if (decoded_o) begin
            flags_o[FlagN] = res[DataW-1];
            flags_o[FlagZ] = (res == '0);
            if (is_arith) begin
                flags_o[FlagC] = ext_sum[DataW];
                flags_o[FlagV] = (is_sub ? (op_a_i[DataW-1] != op_b_i[DataW-1])
                                         : (op_a_i[DataW-1] == op_b_i[DataW-1]))
                               && (res[DataW-1] != op_a_i[DataW-1]);
            end else begin
                flags_o[FlagC] = shift_carry_i;
            end
        end

        result_o = res;
    end

endmodule

// File: rtl/status_flag_unit.sv
// CPSR-style flag register with exception save/restore and a saturating commit counter.
// Optional STATUS_FLAG_BYPASS_EN forwards about-to-commit flags combinationally to N/Z/C/V.
module status_flag_unit
    import status_flag_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              s_bit,
    input  logic              flush,
    input  logic [3:0]        exe_cmd,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              shift_carry,
    output logic [DATA_W-1:0] alu_result,
    input  logic              exc_entry,
    input  logic              exc_return,
    output logic              N,
    output logic              Z,
    output logic              C,
    output logic              V,
    output logic [3:0]        spsr_flags,
    output logic [7:0]        upd_count
);

    localparam logic [7:0] CntMax = 8'hFF;

    flags_t     flags_q, flags_d;
    flags_t     spsr_q, spsr_d;
    logic [7:0] cnt_q, cnt_d;

    flags_t     alu_flags;
    logic       decoded;
    logic       test_op;
    logic       commit;
    logic       restore;
    flags_t     flags_out;

    flag_alu #(
        .DataW(DATA_W)
    ) u_flag_alu (
        .cmd_i        (exe_cmd),
        .op_a_i       (op_a),
        .op_b_i       (op_b),
        .shift_carry_i(shift_carry),
        .flags_i      (flags_q),
        .result_o     (alu_result),
        .flags_o      (alu_flags),
        .decoded_o    (decoded),
        .test_op_o    (test_op)
    );

    always_comb begin
        commit  = valid_in && !flush && decoded && (s_bit || test_op);
        // A simultaneous entry wins: the return is dropped entirely.
        restore = exc_return && !exc_entry;

        flags_d = flags_q;
        if (restore) begin
            flags_d = spsr_q;
        end else if (commit) begin
            flags_d = alu_flags;
        end

        spsr_d = exc_entry ? flags_q : spsr_q;

        cnt_d = cnt_q;
        if (commit && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
            spsr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            flags_q <= flags_d;
            spsr_q  <= spsr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
`ifdef STATUS_FLAG_BYPASS_EN
        flags_out = rst ? '0 : flags_d;
`else
        flags_out = flags_q;
`endif
    end

    assign N          = flags_out[FlagN];
    assign Z          = flags_out[FlagZ];
    assign C          = flags_out[FlagC];
    assign V          = flags_out[FlagV];
    assign spsr_flags = spsr_q;
    assign upd_count  = cnt_q;

endmodule

// File: tb/tb_status_flag_unit.sv
// Directed self-checking bench for status_flag_unit; flags compared as {N,Z,C,V}.
module tb_status_flag_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, s_bit, flush, shift_carry, exc_entry, exc_return;
    logic [3:0]  exe_cmd;
    logic [31:0] op_a, op_b, alu_result;
    logic        N, Z, C, V;
    logic [3:0]  spsr_flags;
    logic [7:0]  upd_count;
    wire  [3:0]  nzcv = {N, Z, C, V};

    int n_checks = 0;
    int n_fail   = 0;

    status_flag_unit #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .s_bit      (s_bit),
        .flush      (flush),
        .exe_cmd    (exe_cmd),
        .op_a       (op_a),
        .op_b       (op_b),
        .shift_carry(shift_carry),
        .alu_result (alu_result),
        .exc_entry  (exc_entry),
        .exc_return (exc_return),
        .N          (N),
        .Z          (Z),
        .C          (C),
        .V          (V),
        .spsr_flags (spsr_flags),
        .upd_count  (upd_count)
    );

    always #5 clk = ~clk;

    // Drive an operation at the falling edge so it is stable for the next rising edge.
    task automatic present(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic fl, input logic sc,
                           input logic ent, input logic ret);
        @(negedge clk);
        valid_in = 1'b1; exe_cmd = cmd; op_a = a; op_b = b;
        s_bit = s; flush = fl; shift_carry = sc; exc_entry = ent; exc_return = ret;
    endtask

    task automatic edge_and_idle();
        @(posedge clk);
        #1;
        valid_in = 1'b0; s_bit = 1'b0; flush = 1'b0; exc_entry = 1'b0; exc_return = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (nzcv !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags got %b want 0000", nzcv);
        end
        n_checks++;
        if (spsr_flags !== 4'b0000) begin
            n_fail++; $display("FAIL reset_spsr got %b want 0000", spsr_flags);
        end
        n_checks++;
        if (upd_count !== 8'd0) begin
            n_fail++; $display("FAIL reset_count got %0d want 0", upd_count);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add_sub();
        present(4'h2, 32'h7FFF_FFFF, 32'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (alu_result !== 32'h8000_0000) begin
            n_fail++; $display("FAIL add_result got %h want 80000000", alu_result);
        end
        edge_and_idle();
        n_checks++;
        if (nzcv !== 4'b1001) begin
            n_fail++; $display("FAIL add_ovf_flags got %b want 1001", nzcv);
        end
        n_checks++;
        if (upd_count !== 8'd1) begin
            n_fail++; $display("FAIL add_ovf_count got %0d want 1", upd_count);
        end
        present(4'h4, 32'd5, 32'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        edge_and_idle();
        n_checks++;
        if (nzcv !== 4'b1001 || upd_count !== 8'd1) begin
            n_fail++; $display("FAIL sub_flush got %b/%0d want 1001/1", nzcv, upd_count);
        end
        present(4'h4, 32'd5, 32'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        edge_and_idle();
        n_checks++;
        if (nzcv !== 4'b0110 || upd_count !== 8'd2) begin
            n_fail++; $display("FAIL sub_zero got %b/%0d want 0110/2", nzcv, upd_count);
        end
    endtask

    task automatic test_cmp_tst();
        present(4'hA, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        edge_and_idle();
        n_checks++;
        if (nzcv !== 4'b1000 || upd_count !== 8'd3) begin
            n_fail++; $display("FAIL cmp_nosbit got %b/%0d want 1000/3", nzcv, upd_count);
        end
        present(4'h2, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        edge_and_idle();
        n_checks++;
        if (nzcv !== 4'b1000 || upd_count !== 8'd3) begin
            n_fail++; $display("FAIL add_nosbit got %b/%0d want 1000/3", nzcv, upd_count);
        end
        present(4'hB, 32'hF0, 32'h0F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        edge_and_idle();
        n_checks++;
        if (nzcv !== 4'b0110 || upd_count !== 8'd4) begin
            n_fail++; $display("FAIL tst_nosbit got %b/%0d want 0110/4", nzcv, upd_count);
        end
        present(4'hF, 32'd5, 32'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (alu_result !== 32'd0) begin
            n_fail++; $display("FAIL undecoded_result got %h want 0", alu_result);
        end
        edge_and_idle();
        n_checks++;
        if (nzcv !== 4'b0110 || upd_count !== 8'd4) begin
            n_fail++; $display("FAIL undecoded_flags got %b/%0d want 0110/4", nzcv, upd_count);
        end
    endtask

    task automatic test_carry_logic();
        logic [3:0]  cmds [7]  = '{4'h3, 4'h5, 4'h4, 4'h8, 4'h1, 4'h7, 4'h2};
        logic [31:0] as   [7]  = '{32'd1, 32'd10, 32'h8000_0000, 32'hFFFF_0000, 32'd0, 32'd0,
                                   32'd0};
        logic [31:0] bs   [7]  = '{32'd2, 32'd3, 32'd1, 32'h0000_FFFF, 32'd0, 32'h8000_0000,
                                   32'd0};
        logic        scs  [7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] rexp [7]  = '{32'd4, 32'd6, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0,
                                   32'h8000_0000, 32'd0};
        logic [3:0]  fexp [7]  = '{4'b0000, 4'b0010, 4'b0011, 4'b1001, 4'b0111, 4'b1001,
                                   4'b0100};
        for (int i = 0; i < 7; i++) begin
            present(cmds[i], as[i], bs[i], 1'b1, 1'b0, scs[i], 1'b0, 1'b0);
            #1;
            n_checks++;
            if (alu_result !== rexp[i]) begin
                n_fail++; $display("FAIL op%0d_result got %h want %h", i, alu_result, rexp[i]);
            end
            edge_and_idle();
            n_checks++;
            if (nzcv !== fexp[i] || upd_count !== 8'(5 + i)) begin
                n_fail++;
                $display("FAIL op%0d_flags got %b/%0d want %b/%0d", i, nzcv, upd_count,
                         fexp[i], 5 + i);
            end
        end
    endtask

    task automatic test_exception();
        present(4'h7, 32'h8000_0000, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        edge_and_idle();
        n_checks++;
        if (nzcv !== 4'b1010) begin
            n_fail++; $display("FAIL exc_setup got %b want 1010", nzcv);
        end
        present(4'h2, 32'd1, 32'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        edge_and_idle();
        n_checks++;
        if (spsr_flags !== 4'b1010 || nzcv !== 4'b0000) begin
            n_fail++; $display("FAIL exc_entry got spsr %b cpsr %b want 1010/0000",
                               spsr_flags, nzcv);
        end
        n_checks++;
        if (upd_count !== 8'd13) begin
            n_fail++; $display("FAIL exc_entry_count got %0d want 13", upd_count);
        end
        present(4'h2, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        edge_and_idle();
        n_checks++;
        if (nzcv !== 4'b1010 || spsr_flags !== 4'b1010) begin
            n_fail++; $display("FAIL exc_return got cpsr %b spsr %b want 1010/1010",
                               nzcv, spsr_flags);
        end
        present(4'h2, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        edge_and_idle();
        n_checks++;
        if (nzcv !== 4'b0100 || spsr_flags !== 4'b1010) begin
            n_fail++; $display("FAIL exc_both got cpsr %b spsr %b want 0100/1010",
                               nzcv, spsr_flags);
        end
    endtask

    task automatic test_saturate_reset();
        present(4'h2, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (300) @(posedge clk);
        #1;
        n_checks++;
        if (upd_count !== 8'd255) begin
            n_fail++; $display("FAIL saturate got %0d want 255", upd_count);
        end
        #2;
        rst = 1'b1;
        exc_entry = 1'b1;
        #1;
        n_checks++;
        if (nzcv !== 4'b0000 || spsr_flags !== 4'b0000 || upd_count !== 8'd0) begin
            n_fail++; $display("FAIL async_reset got %b/%b/%0d want 0000/0000/0",
                               nzcv, spsr_flags, upd_count);
        end
        exe_cmd = 4'h2; op_a = 32'h7FFF_FFFF; op_b = 32'd1;
        @(posedge clk);
        #1;
        n_checks++;
        if (nzcv !== 4'b0000 || upd_count !== 8'd0) begin
            n_fail++; $display("FAIL reset_discard got %b/%0d want 0000/0", nzcv, upd_count);
        end
        valid_in = 1'b0; s_bit = 1'b0; exc_entry = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (nzcv !== 4'b0000 || spsr_flags !== 4'b0000 || upd_count !== 8'd0) begin
            n_fail++; $display("FAIL post_reset got %b/%b/%0d want 0000/0000/0",
                               nzcv, spsr_flags, upd_count);
        end
    endtask

    task automatic test_bypass();
        logic z_early;
`ifdef STATUS_FLAG_BYPASS_EN
        z_early = 1'b1;
`else
        z_early = 1'b0;
`endif
        present(4'h2, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (Z !== z_early) begin
            n_fail++; $display("FAIL bypass_same_cycle got Z=%b want %b", Z, z_early);
        end
        edge_and_idle();
        n_checks++;
        if (nzcv !== 4'b0100 || upd_count !== 8'd1) begin
            n_fail++; $display("FAIL bypass_next_cycle got %b/%0d want 0100/1", nzcv, upd_count);
        end
    endtask

    initial begin
        rst = 1'b1;
        valid_in = 1'b0; s_bit = 1'b0; flush = 1'b0; shift_carry = 1'b0;
        exc_entry = 1'b0; exc_return = 1'b0;
        exe_cmd = 4'h0; op_a = '0; op_b = '0;
        test_reset();
        test_add_sub();
        test_cmp_tst();
        test_carry_logic();
        test_exception();
        test_saturate_reset();
        test_bypass();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
